reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_pkg.sv | 19 +
 rtl/reservation_station_age_select.sv | 33 +++
 rtl/reservation_station.sv | 164 ++++++++++++++++
 tb/tb_reservation_station.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared widths, control-field layout and CDB port map
package reservation_station_pkg;
    localparam int TAG_W         = 4;
    localparam int DATA_W        = 32;
    localparam int CTRL_W        = 10;
    localparam int CTRL_ALU_HI   = 9;
    localparam int CTRL_ALU_LO   = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_BRANCH   = 1;
    localparam int CTRL_BRANCHN  = 0;
    localparam int CDB_ROB       = 0;
    localparam int CDB_MEM       = 1;
    localparam int CDB_WB1       = 2;
    localparam int CDB_WB2       = 3;
    localparam int CDB_PORTS     = 4;
endpackage

// File: rtl/reservation_station_age_select.sv
// rs_age_select: picks the ready entry whose tag is closest to the ROB head
module rs_age_select
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = reservation_station_pkg::TAG_W,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0]       i_ready,
    input  logic [DEPTH*TAG_W-1:0] i_tags,
    input  logic [TAG_W-1:0]       i_head,
    output logic                   o_valid,
    output logic [IDX_W-1:0]       o_idx
);
    logic [TAG_W-1:0] w_age;
    logic [TAG_W-1:0] w_best;

    // age is the modular distance from the head; strict compare keeps the lowest index on ties
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_age   = '0;
        w_best  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_age = i_tags[i*TAG_W +: TAG_W] - i_head;
            if (i_ready[i] && (!o_valid || w_age < w_best)) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
                w_best  = w_age;
            end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: operand-capturing issue queue with CDB wakeup and oldest-first issue
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = reservation_station_pkg::TAG_W
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_d1,
    input  logic                           in_v1,
    input  logic [DATA_W-1:0]              in_d2,
    input  logic                           in_v2,
    input  logic [TAG_W-1:0]               in_tag,
    input  logic [4:0]                     in_wreg,
    input  logic [CTRL_W-1:0]              in_ctrl,
    input  logic [DATA_W-1:0]              in_imm,
    input  logic [DATA_W-1:0]              in_pc4,
    input  logic [CDB_PORTS-1:0]           cdb_en,
    input  logic [CDB_PORTS*TAG_W-1:0]     cdb_tag,
    input  logic [CDB_PORTS*DATA_W-1:0]    cdb_data,
    input  logic                           flush,
    input  logic [TAG_W-1:0]               rob_head,
    output logic                           stall,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_d1,
    output logic [DATA_W-1:0]              out_d2,
    output logic [TAG_W-1:0]               out_tag,
    output logic [4:0]                     out_wreg,
    output logic [CTRL_W-1:0]              out_ctrl,
    output logic [DATA_W-1:0]              out_imm,
    output logic [DATA_W-1:0]              out_pc4
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]       r_busy, r_v1, r_v2;
    logic [DATA_W-1:0]      r_d1   [DEPTH];
    logic [DATA_W-1:0]      r_d2   [DEPTH];
    logic [TAG_W-1:0]       r_tag  [DEPTH];
    logic [4:0]             r_wreg [DEPTH];
    logic [CTRL_W-1:0]      r_ctrl [DEPTH];
    logic [DATA_W-1:0]      r_imm  [DEPTH];
    logic [DATA_W-1:0]      r_pc4  [DEPTH];

    logic [DATA_W:0]        w_wake1 [DEPTH];
    logic [DATA_W:0]        w_wake2 [DEPTH];
    logic [DATA_W:0]        w_in1, w_in2;
    logic [DEPTH-1:0]       w_ready;
    logic [DEPTH*TAG_W-1:0] w_tags;
    logic                   w_alloc_ok;
    logic [IDX_W-1:0]       w_alloc_idx;
    logic                   w_iss_valid;
    logic [IDX_W-1:0]       w_iss_idx;

    // returns {valid, data}; scanning high to low lets the lowest matching port win
    function automatic logic [DATA_W:0] wake(
        input logic [DATA_W-1:0]           d,
        input logic                        v,
        input logic [CDB_PORTS-1:0]        en,
        input logic [CDB_PORTS*TAG_W-1:0]  tags,
        input logic [CDB_PORTS*DATA_W-1:0] data
    );
        wake = {v, d};
        for (int k = CDB_PORTS - 1; k >= 0; k--)
            if (!v && en[k] && tags[k*TAG_W +: TAG_W] == d[TAG_W-1:0])
                wake = {1'b1, data[k*DATA_W +: DATA_W]};
    endfunction

    assign stall = &r_busy;

    // wakeup candidates for stored and incoming operands, plus issue readiness
    always_comb begin
        w_in1   = wake(in_d1, in_v1, cdb_en, cdb_tag, cdb_data);
        w_in2   = wake(in_d2, in_v2, cdb_en, cdb_tag, cdb_data);
        w_ready = '0;
        w_tags  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wake1[i] = wake(r_d1[i], r_v1[i], cdb_en, cdb_tag, cdb_data);
            w_wake2[i] = wake(r_d2[i], r_v2[i], cdb_en, cdb_tag, cdb_data);
            w_ready[i] = r_busy[i] & r_v1[i] & r_v2[i];
            w_tags[i*TAG_W +: TAG_W] = r_tag[i];
        end
    end

    // lowest-index free entry; only registered busy bits count, so an issuing entry is not reused this edge
    always_comb begin
        w_alloc_ok  = 1'b0;
        w_alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!r_busy[i]) begin
                w_alloc_ok  = 1'b1;
                w_alloc_idx = IDX_W'(i);
            end
    end

    rs_age_select #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_age (
        .i_ready (w_ready),
        .i_tags  (w_tags),
        .i_head  (rob_head),
        .o_valid (w_iss_valid),
        .o_idx   (w_iss_idx)
    );

    // entry state and issue register; flush overrides wakeup, issue and allocation
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_busy    <= '0;
            r_v1      <= '0;
            r_v2      <= '0;
            out_valid <= 1'b0;
            out_d1    <= '0;
            out_d2    <= '0;
            out_tag   <= '0;
            out_wreg  <= '0;
            out_ctrl  <= '0;
            out_imm   <= '0;
            out_pc4   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d1[i]   <= '0;
                r_d2[i]   <= '0;
                r_tag[i]  <= '0;
                r_wreg[i] <= '0;
                r_ctrl[i] <= '0;
                r_imm[i]  <= '0;
                r_pc4[i]  <= '0;
            end
        end else if (flush) begin
            r_busy    <= '0;
            out_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (r_busy[i]) begin
                    {r_v1[i], r_d1[i]} <= w_wake1[i];
                    {r_v2[i], r_d2[i]} <= w_wake2[i];
                end
            out_valid <= w_iss_valid;
            if (w_iss_valid) begin
                r_busy[w_iss_idx] <= 1'b0;
                out_d1   <= r_d1[w_iss_idx];
                out_d2   <= r_d2[w_iss_idx];
                out_tag  <= r_tag[w_iss_idx];
                out_wreg <= r_wreg[w_iss_idx];
                out_ctrl <= r_ctrl[w_iss_idx];
                out_imm  <= r_imm[w_iss_idx];
                out_pc4  <= r_pc4[w_iss_idx];
            end
            if (in_valid && w_alloc_ok) begin
                r_busy[w_alloc_idx]             <= 1'b1;
                {r_v1[w_alloc_idx], r_d1[w_alloc_idx]} <= w_in1;
                {r_v2[w_alloc_idx], r_d2[w_alloc_idx]} <= w_in2;
                r_tag[w_alloc_idx]              <= in_tag;
                r_wreg[w_alloc_idx]             <= in_wreg;
                r_ctrl[w_alloc_idx]             <= in_ctrl;
                r_imm[w_alloc_idx]              <= in_imm;
                r_pc4[w_alloc_idx]              <= in_pc4;
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: scenario tasks with a queue of expected issues
module tb_reservation_station;
    logic         CLK = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  in_d1 = '0, in_d2 = '0, in_imm = '0, in_pc4 = '0;
    logic         in_v1 = 1'b0, in_v2 = 1'b0;
    logic [3:0]   in_tag = '0;
    logic [4:0]   in_wreg = '0;
    logic [9:0]   in_ctrl = '0;
    logic [3:0]   cdb_en = '0;
    logic [15:0]  cdb_tag = '0;
    logic [127:0] cdb_data = '0;
    logic         flush = 1'b0;
    logic [3:0]   rob_head = '0;
    logic         stall, out_valid;
    logic [31:0]  out_d1, out_d2, out_imm, out_pc4;
    logic [3:0]   out_tag;
    logic [4:0]   out_wreg;
    logic [9:0]   out_ctrl;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  wreg;
        logic [9:0]  ctrl;
        logic [31:0] imm;
        logic [31:0] pc4;
    } rec_t;

    rec_t exp_q[$];
    rec_t got, e;
    int   checks = 0;
    int   errors = 0;

    assign got = {out_tag, out_d1, out_d2, out_wreg, out_ctrl, out_imm, out_pc4};

    reservation_station #(.DEPTH(4), .TAG_W(4)) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid),
        .in_d1(in_d1), .in_v1(in_v1), .in_d2(in_d2), .in_v2(in_v2),
        .in_tag(in_tag), .in_wreg(in_wreg), .in_ctrl(in_ctrl),
        .in_imm(in_imm), .in_pc4(in_pc4),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .rob_head(rob_head), .stall(stall),
        .out_valid(out_valid), .out_d1(out_d1), .out_d2(out_d2),
        .out_tag(out_tag), .out_wreg(out_wreg), .out_ctrl(out_ctrl),
        .out_imm(out_imm), .out_pc4(out_pc4)
    );

    always #5 CLK = ~CLK;

    function automatic rec_t mk(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
        rec_t r;
        r.tag  = t;
        r.d1   = a;
        r.d2   = b;
        r.wreg = 5'(t + 1);
        r.ctrl = {t, 6'h15};
        r.imm  = 32'h1000 + 32'(t);
        r.pc4  = 32'h400 + 32'(t) * 4;
        return r;
    endfunction

    task automatic drive(input logic [3:0] t, input logic [31:0] a, input logic va,
                         input logic [31:0] b, input logic vb);
        in_valid = 1'b1;
        in_tag   = t;
        in_d1    = a;
        in_v1    = va;
        in_d2    = b;
        in_v2    = vb;
        in_wreg  = 5'(t + 1);
        in_ctrl  = {t, 6'h15};
        in_imm   = 32'h1000 + 32'(t);
        in_pc4   = 32'h400 + 32'(t) * 4;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cdb_en   = '0;
        flush    = 1'b0;
    endtask

    task automatic bcast(input int k, input logic [3:0] t, input logic [31:0] d);
        cdb_en[k]            = 1'b1;
        cdb_tag[k*4 +: 4]    = t;
        cdb_data[k*32 +: 32] = d;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: out_valid=%b stall=%b, required 0 0", out_valid, stall);
        end
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h, required 0", got);
        end
        @(negedge CLK);
        reset = 1'b1;
    endtask

    task automatic test_issue();
        drive(3, 5, 1, 7, 1);
        exp_q.push_back(mk(3, 5, 7));
        @(negedge CLK);
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL issue_early: out_valid=%b, required 0", out_valid);
        end
        @(negedge CLK);
        e = exp_q.size() ? exp_q.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL issue_ready: out_valid=%b got %h, required 1 %h", out_valid, got, e);
        end
    endtask

    task automatic test_wakeup();
        drive(5, 6, 0, 32'h77, 1);
        bcast(0, 9, 32'hDEAD);
        exp_q.push_back(mk(5, 32'h1234, 32'h77));
        @(negedge CLK);
        idle();
        bcast(1, 6, 32'h1234);
        bcast(0, 7, 32'hBAD);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_waiting: out_valid=%b, required 0", out_valid);
        end
        @(negedge CLK);
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_latency: out_valid=%b, required 0", out_valid);
        end
        @(negedge CLK);
        e = exp_q.size() ? exp_q.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL wake_issue: out_valid=%b got %h, required 1 %h", out_valid, got, e);
        end
    endtask

    task automatic test_same_edge();
        drive(7, 32'hA, 0, 32'hA, 0);
        bcast(1, 10, 32'h1111);
        bcast(3, 10, 32'h3333);
        exp_q.push_back(mk(7, 32'h1111, 32'h1111));
        @(negedge CLK);
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_early: out_valid=%b, required 0", out_valid);
        end
        @(negedge CLK);
        e = exp_q.size() ? exp_q.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL same_edge_issue: out_valid=%b got %h, required 1 %h", out_valid, got, e);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            drive(4'(8 + i), 32'(1 + i), 0, 32'hC0 + 32'(i), 1);
            @(negedge CLK);
        end
        idle();
        checks++;
        if (stall !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_full: stall=%b out_valid=%b, required 1 0", stall, out_valid);
        end
        drive(12, 1, 1, 2, 1);
        @(negedge CLK);
        idle();
        checks++;
        if (stall !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_ignore: stall=%b out_valid=%b, required 1 0", stall, out_valid);
        end
        bcast(0, 3, 32'h33);
        exp_q.push_back(mk(10, 32'h33, 32'hC2));
        @(negedge CLK);
        idle();
        checks++;
        if (stall !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_wake: stall=%b out_valid=%b, required 1 0", stall, out_valid);
        end
        @(negedge CLK);
        e = exp_q.size() ? exp_q.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL stall_issue: out_valid=%b got %h, required 1 %h", out_valid, got, e);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: stall=%b, required 0", stall);
        end
    endtask

    task automatic test_flush();
        bcast(0, 1, 32'h11);
        @(negedge CLK);
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre: out_valid=%b, required 0", out_valid);
        end
        flush = 1'b1;
        drive(13, 1, 1, 1, 1);
        @(negedge CLK);
        idle();
        checks++;
        if (out_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_edge: out_valid=%b stall=%b, required 0 0", out_valid, stall);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_empty%0d: out_valid=%b, required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_age();
        rob_head = 13;
        drive(2, 5, 0, 32'h22, 1);
        @(negedge CLK);
        drive(14, 5, 0, 32'hEE, 1);
        @(negedge CLK);
        idle();
        bcast(2, 5, 32'h55);
        exp_q.push_back(mk(14, 32'h55, 32'hEE));
        exp_q.push_back(mk(2, 32'h55, 32'h22));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL age_waiting: out_valid=%b, required 0", out_valid);
        end
        @(negedge CLK);
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            e = exp_q.size() ? exp_q.pop_front() : '0;
            checks++;
            if (out_valid !== 1'b1 || got !== e) begin
                errors++;
                $display("FAIL age_order%0d: out_valid=%b got %h, required 1 %h", i, out_valid, got, e);
            end
        end
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || got !== e) begin
            errors++;
            $display("FAIL age_hold: out_valid=%b got %h, required 0 %h", out_valid, got, e);
        end
        rob_head = 0;
    endtask

    task automatic test_reset_mid();
        drive(4, 32'h44, 1, 32'h45, 1);
        exp_q.push_back(mk(4, 32'h44, 32'h45));
        @(negedge CLK);
        drive(6, 9, 0, 32'h66, 1);
        @(negedge CLK);
        idle();
        e = exp_q.size() ? exp_q.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL rst_pre_issue: out_valid=%b got %h, required 1 %h", out_valid, got, e);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall !== 1'b0 || got !== '0) begin
            errors++;
            $display("FAIL rst_async: out_valid=%b stall=%b got %h, required 0 0 0", out_valid, stall, got);
        end
        @(negedge CLK);
        reset = 1'b1;
        bcast(0, 9, 32'h99);
        @(negedge CLK);
        idle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_discard%0d: out_valid=%b, required 0", i, out_valid);
            end
            @(negedge CLK);
        end
        drive(1, 32'h10, 1, 32'h20, 1);
        exp_q.push_back(mk(1, 32'h10, 32'h20));
        @(negedge CLK);
        idle();
        @(negedge CLK);
        e = exp_q.size() ? exp_q.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL rst_first_alloc: out_valid=%b got %h, required 1 %h", out_valid, got, e);
        end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_wakeup();
        test_same_edge();
        test_stall();
        test_flush();
        test_age();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
